// File: rtl/vid_pkg.sv
// vid_pkg -- shared definitions for the colour-bar video generator.
//   * default 1080p timing constants
//   * 10-bit BT.709 legal-range Y/Cb/Cr values for the eight 75% bars and blanking
//   * horizontal state enum and TRS word constants
//   * bar_colour(): bar index -> Y/Cb/Cr triple
package vid_pkg;

  // Default timing (1920x1080 progressive, 2200x1125 total)
  localparam int H_ACTIVE_DEF = 1920;
  localparam int H_TOTAL_DEF  = 2200;
  localparam int V_ACTIVE_DEF = 1080;
  localparam int V_TOTAL_DEF  = 1125;

  typedef enum logic [1:0] {H_ACT, H_EAV, H_BLK, H_SAV} h_state_t;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;

  // 75% colour bars, 10-bit legal range
  localparam ycbcr_t C_WHITE   = '{y: 10'h2D1, cb: 10'h200, cr: 10'h200};
  localparam ycbcr_t C_YELLOW  = '{y: 10'h2A2, cb: 10'h0B0, cr: 10'h21F};
  localparam ycbcr_t C_CYAN    = '{y: 10'h245, cb: 10'h24D, cr: 10'h0B0};
  localparam ycbcr_t C_GREEN   = '{y: 10'h216, cb: 10'h0FD, cr: 10'h0CF};
  localparam ycbcr_t C_MAGENTA = '{y: 10'h0FB, cb: 10'h303, cr: 10'h331};
  localparam ycbcr_t C_RED     = '{y: 10'h0CC, cb: 10'h1B3, cr: 10'h350};
  localparam ycbcr_t C_BLUE    = '{y: 10'h06F, cb: 10'h350, cr: 10'h1E1};
  localparam ycbcr_t C_BLACK   = '{y: 10'h040, cb: 10'h200, cr: 10'h200};

  // Blanking level
  localparam logic [9:0] BLANK_Y = 10'h040;
  localparam logic [9:0] BLANK_C = 10'h200;

  // TRS preamble words; the fourth word is the XYZ status word
  localparam logic [9:0] TRS_WORD0  = 10'h3FF;
  localparam logic [9:0] TRS_WORD12 = 10'h000;

  // {F,V,H,T} while the generator is stopped or in reset
  localparam logic [3:0] FVHT_IDLE = 4'b0110;

  // Bar index 0..7 (left to right) to colour
  function automatic ycbcr_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return C_WHITE;
      3'd1:    return C_YELLOW;
      3'd2:    return C_CYAN;
      3'd3:    return C_GREEN;
      3'd4:    return C_MAGENTA;
      3'd5:    return C_RED;
      3'd6:    return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vid_trs_enc.sv
// vid_trs_enc -- combinational TRS word encoder.
// Ports:
//   f_i, v_i, hx_i : field, vertical blank, EAV(1)/SAV(0) flag
//   word_i         : word index 0..3 within the TRS
//   trs_o          : 10-bit TRS word (3FF, 000, 000, XYZ)
module vid_trs_enc
  import vid_pkg::*;
(
  input  logic       f_i,
  input  logic       v_i,
  input  logic       hx_i,
  input  logic [1:0] word_i,
  output logic [9:0] trs_o
);

  // Select preamble or XYZ; XYZ carries protection bits P3..P0
  always_comb begin
    case (word_i)
      2'd0:    trs_o = TRS_WORD0;
      2'd1:    trs_o = TRS_WORD12;
      2'd2:    trs_o = TRS_WORD12;
      2'd3:    trs_o = {1'b1, f_i, v_i, hx_i,
                        v_i ^ hx_i, f_i ^ hx_i, f_i ^ v_i, f_i ^ v_i ^ hx_i,
                        2'b00};
      default: trs_o = TRS_WORD12;
    endcase
  end

endmodule

// File: rtl/vid_bars_gen.sv
// vid_bars_gen -- 4:2:2 colour-bar test pattern generator with SAV/EAV TRS.
// Ports:
//   clk_i        video clock
//   rst_n_i      async active-low reset (deassertion synchronised internally)
//   cen_i        clock enable, all generator state advances only when high
//   run_i        run; low holds counters and drives blanking
//   vdat_bars_o  {luma[19:10], chroma[9:0]}, Cb on even / Cr on odd samples
//   fvht_o       {F,V,H,T} timing flags, sample-aligned with vdat_bars_o
//   sof_o        one-sample pulse on first active sample of a frame
//   x_o, y_o     active pixel/line coordinates (macro VID_BARS_GEN_COORD_EN),
//                otherwise tied to zero
// All outputs are registered, one enabled clock after the counter state they
// describe.
module vid_bars_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic        run_i,
  output logic [19:0] vdat_bars_o,
  output logic [3:0]  fvht_o,
  output logic        sof_o,
  output logic [11:0] x_o,
  output logic [10:0] y_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  // TRS word index is the low two bits of the offset into the TRS slot
  localparam logic [1:0] EAV_OFS = 2'(H_ACTIVE);
  localparam logic [1:0] SAV_OFS = 2'(H_TOTAL - 4);

  logic [1:0]  rst_sync_q;
  logic        adv_en;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  h_state_t    h_state_q, h_state_d;
  logic [19:0] vdat_q, vdat_d;
  logic [3:0]  fvht_q, fvht_d;
  logic        sof_q, sof_d;
  logic        v_blank, h_blank, is_trs;
  logic [1:0]  trs_idx;
  logic [9:0]  trs_word;
  logic [2:0]  bar_idx;
  ycbcr_t      bar_c;

  // Reset synchroniser: free-running so release timing does not depend on cen_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign adv_en = cen_i & rst_sync_q[1];

  // Next counter values with wrap at the line and frame ends
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == 12'(H_TOTAL - 1)) begin
      h_cnt_d = 12'd0;
      if (v_cnt_q == 11'(V_TOTAL - 1)) v_cnt_d = 11'd0;
      else                             v_cnt_d = v_cnt_q + 11'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
  end

  // Horizontal state transitions, only at region boundaries
  always_comb begin
    h_state_d = h_state_q;
    case (h_state_q)
      H_ACT:   if (h_cnt_q == 12'(H_ACTIVE - 1)) h_state_d = H_EAV; else h_state_d = H_ACT;
      H_EAV:   if (h_cnt_q == 12'(H_ACTIVE + 3)) h_state_d = H_BLK; else h_state_d = H_EAV;
      H_BLK:   if (h_cnt_q == 12'(H_TOTAL - 5))  h_state_d = H_SAV; else h_state_d = H_BLK;
      H_SAV:   if (h_cnt_q == 12'(H_TOTAL - 1))  h_state_d = H_ACT; else h_state_d = H_SAV;
      default: h_state_d = H_ACT;
    endcase
  end

  assign v_blank = (v_cnt_q >= 11'(V_ACTIVE));
  assign h_blank = (h_state_q != H_ACT);
  assign is_trs  = (h_state_q == H_EAV) || (h_state_q == H_SAV);
  assign trs_idx = (h_state_q == H_EAV) ? (h_cnt_q[1:0] - EAV_OFS)
                                        : (h_cnt_q[1:0] - SAV_OFS);

  vid_trs_enc u_trs_enc (
    .f_i    (1'b0),
    .v_i    (v_blank),
    .hx_i   (h_state_q == H_EAV),
    .word_i (trs_idx),
    .trs_o  (trs_word)
  );

  // Bar index: count how many bar boundaries lie at or left of h_cnt
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= 12'(k * BAR_W)) bar_idx = 3'(k);
      else                           bar_idx = bar_idx;
    end
  end

  assign bar_c = bar_colour(bar_idx);

  // Output word and timing flags for the current counter state
  always_comb begin
    if (is_trs) begin
      vdat_d = {trs_word, trs_word};
    end else if (h_blank || v_blank) begin
      vdat_d = {BLANK_Y, BLANK_C};
    end else begin
      vdat_d = {bar_c.y, h_cnt_q[0] ? bar_c.cr : bar_c.cb};
    end
    fvht_d = {1'b0, v_blank, h_blank, is_trs};
    sof_d  = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
  end

  // Counters, horizontal FSM and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 11'(V_ACTIVE);
      h_state_q <= H_ACT;
      vdat_q    <= {BLANK_Y, BLANK_C};
      fvht_q    <= FVHT_IDLE;
      sof_q     <= 1'b0;
    end else if (adv_en) begin
      if (run_i) begin
        h_cnt_q   <= h_cnt_d;
        v_cnt_q   <= v_cnt_d;
        h_state_q <= h_state_d;
        vdat_q    <= vdat_d;
        fvht_q    <= fvht_d;
        sof_q     <= sof_d;
      end else begin
        vdat_q <= {BLANK_Y, BLANK_C};
        fvht_q <= FVHT_IDLE;
        sof_q  <= 1'b0;
      end
    end
  end

  assign vdat_bars_o = vdat_q;
  assign fvht_o      = fvht_q;
  assign sof_o       = sof_q;

`ifdef VID_BARS_GEN_COORD_EN
  logic [11:0] x_q;
  logic [10:0] y_q;

  // Capture coordinates of active samples; blanking keeps the last active ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_q <= 12'd0;
      y_q <= 11'd0;
    end else if (adv_en && run_i && !h_blank && !v_blank) begin
      x_q <= h_cnt_q;
      y_q <= v_cnt_q;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
`else
  assign x_o = 12'd0;
  assign y_o = 11'd0;
`endif

endmodule

// File: tb/tb_vid_bars_gen.sv
// Self-checking bench for vid_bars_gen with scaled-down timing so that whole
// frames fit in a short run. Reference model works in plain integer (h, v)
// raster positions and derives colours from the BT.709 equations.
module tb_vid_bars_gen;

  localparam int HA = 64;
  localparam int HT = 80;
  localparam int VA = 6;
  localparam int VT = 9;
  localparam int BW = HA / 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        cen_i = 1'b0;
  logic        run_i = 1'b0;
  logic [19:0] vdat_bars_o;
  logic [3:0]  fvht_o;
  logic        sof_o;
  logic [11:0] x_o;
  logic [10:0] y_o;

  vid_bars_gen #(
    .H_ACTIVE (HA),
    .H_TOTAL  (HT),
    .V_ACTIVE (VA),
    .V_TOTAL  (VT)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cen_i       (cen_i),
    .run_i       (run_i),
    .vdat_bars_o (vdat_bars_o),
    .fvht_o      (fvht_o),
    .sof_o       (sof_o),
    .x_o         (x_o),
    .y_o         (y_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  int cy[8];
  int ccb[8];
  int ccr[8];
  int rgb_tab[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  logic [9:0] eav_v0[4] = '{10'h3FF, 10'h000, 10'h000, 10'h274};
  logic [9:0] sav_v0[4] = '{10'h3FF, 10'h000, 10'h000, 10'h200};
  logic [9:0] eav_v1[4] = '{10'h3FF, 10'h000, 10'h000, 10'h2D8};
  logic [9:0] sav_v1[4] = '{10'h3FF, 10'h000, 10'h000, 10'h2AC};

  int          m_h, m_v, sync_cnt;
  logic [19:0] e_vdat;
  logic [3:0]  e_fvht;
  logic        e_sof;
  logic [11:0] e_x;
  logic [10:0] e_y;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    return $rtoi(x + 0.5);
  endfunction

  task automatic init_colours();
    for (int i = 0; i < 8; i++) begin
      real r, g, b, yl;
      r  = real'((rgb_tab[i] >> 2) & 1);
      g  = real'((rgb_tab[i] >> 1) & 1);
      b  = real'(rgb_tab[i] & 1);
      yl = 0.2126 * r + 0.7152 * g + 0.0722 * b;
      cy[i]  = rnd(64.0 + 876.0 * 0.75 * yl);
      ccb[i] = rnd(512.0 + 896.0 * 0.75 * (b - yl) / 1.8556);
      ccr[i] = rnd(512.0 + 896.0 * 0.75 * (r - yl) / 1.5748);
    end
  endtask

  function automatic logic [9:0] trs_word(input int w, input int vb, input int hx);
    if (w == 0) return 10'h3FF;
    if (w == 3) return 10'(512 + vb * 128 + hx * 64 + (vb ^ hx) * 32 + hx * 16 + vb * 8 + (vb ^ hx) * 4);
    return 10'h000;
  endfunction

  function automatic logic [19:0] exp_vdat(input int h, input int v);
    int vb, b, c;
    logic [9:0] w;
    vb = (v >= VA) ? 1 : 0;
    if (h >= HA && h < HA + 4) begin
      w = trs_word(h - HA, vb, 1);
      return {w, w};
    end
    if (h >= HT - 4) begin
      w = trs_word(h - (HT - 4), vb, 0);
      return {w, w};
    end
    if (h >= HA || vb == 1) return {10'h040, 10'h200};
    b = h / BW;
    c = (h % 2 == 0) ? ccb[b] : ccr[b];
    return {10'(cy[b]), 10'(c)};
  endfunction

  function automatic logic [3:0] exp_fvht(input int h, input int v);
    return {1'b0, (v >= VA), (h >= HA), ((h >= HA && h < HA + 4) || h >= HT - 4)};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = VA; sync_cnt = 0;
    e_vdat = {10'h040, 10'h200};
    e_fvht = 4'b0110;
    e_sof  = 1'b0;
    e_x    = 12'd0;
    e_y    = 11'd0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_vdat"}, vdat_bars_o, e_vdat);
    check_eq({tag, "_fvht"}, fvht_o, e_fvht);
    check_eq({tag, "_sof"}, sof_o, e_sof);
    check_eq({tag, "_x"}, x_o, e_x);
    check_eq({tag, "_y"}, y_o, e_y);
  endtask

  // Literal values from the requirements at specific raster positions
  task automatic directed(input int sh, input int sv);
    if (sv == 0 && sh < 4) check_eq("white_start", vdat_bars_o, {10'h2D1, 10'h200});
    if (sv == 0 && sh == BW) check_eq("yellow_cb", vdat_bars_o, {10'h2A2, 10'h0B0});
    if (sv == 0 && sh >= HA && sh < HA + 4) begin
      check_eq("eav_line0", vdat_bars_o, {eav_v0[sh - HA], eav_v0[sh - HA]});
      check_eq("eav_line0_fvht", fvht_o, 4'b0011);
    end
    if (sv == 0 && sh >= HT - 4) begin
      check_eq("sav_line0", vdat_bars_o, {sav_v0[sh - HT + 4], sav_v0[sh - HT + 4]});
      check_eq("sav_line0_fvht", fvht_o, 4'b0011);
    end
    if (sv == 0 && sh == HA + 4) check_eq("hblk_line0_fvht", fvht_o, 4'b0010);
    if (sv == VA && sh >= HA && sh < HA + 4) begin
      check_eq("eav_vblk", vdat_bars_o, {eav_v1[sh - HA], eav_v1[sh - HA]});
      check_eq("eav_vblk_fvht", fvht_o, 4'b0111);
    end
    if (sv == VA && sh >= HT - 4) begin
      check_eq("sav_vblk", vdat_bars_o, {sav_v1[sh - HT + 4], sav_v1[sh - HT + 4]});
      check_eq("sav_vblk_fvht", fvht_o, 4'b0111);
    end
    if (sv == VA && (sh == 0 || sh == HA + 4)) check_eq("vblk_blank", vdat_bars_o, {10'h040, 10'h200});
    if (sv == VA && sh == 0) check_eq("vblk_fvht", fvht_o, 4'b0100);
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic cen, input logic run);
    int sh, sv;
    logic produced;
    cen_i = cen;
    run_i = run;
    produced = 1'b0;
    sh = 0;
    sv = 0;
    @(posedge clk_i);
    #1;
    if (!rst_n_i) begin
      model_reset();
    end else if (sync_cnt < 2) begin
      sync_cnt++;
    end else if (cen) begin
      if (run) begin
        sh = m_h; sv = m_v; produced = 1'b1;
        e_vdat = exp_vdat(sh, sv);
        e_fvht = exp_fvht(sh, sv);
        e_sof  = (sh == 0 && sv == 0);
`ifdef VID_BARS_GEN_COORD_EN
        if (sh < HA && sv < VA) begin
          e_x = 12'(sh);
          e_y = 11'(sv);
        end
`endif
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) m_v = 0;
        end
      end else begin
        e_vdat = {10'h040, 10'h200};
        e_fvht = 4'b0110;
        e_sof  = 1'b0;
      end
    end
    compare_all("cyc");
    if (produced) directed(sh, sv);
  endtask

  initial begin
    int n;
    logic found;
    init_colours();
    model_reset();

    // Asynchronous reset assertion
    #1 rst_n_i = 1'b0;
    #1 compare_all("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;

    // Stopped generator after release: blanking, counters held
    repeat (4) step(1'b1, 1'b0);

    // First sof after (VT-VA) lines plus one output latency
    n = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1, 1'b1);
      n++;
      if (sof_o) found = 1'b1;
    end
    check_eq("first_sof_cycles", n, (VT - VA) * HT + 1);
    check_eq("sof_fvht", fvht_o, 4'b0000);

    // Continuous run across frame boundaries
    repeat (800) step(1'b1, 1'b1);

    // cen toggling every clock: each value must hold for the disabled clock
    for (int i = 0; i < 800; i++) step((i % 2) == 0, 1'b1);

    // Randomised cen/run
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);

    // Reach mid-line of an active line, then pulse reset between edges
    for (int i = 0; i < 2000 && !(m_h == 40 && m_v == 4); i++) step(1'b1, 1'b1);
    check_eq("seek_mid_line", (m_h == 40 && m_v == 4), 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rst_n_i = 1'b1;

    // After release: two synchroniser clocks, then the blanking lead-in
    n = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1, 1'b1);
      n++;
      if (sof_o) found = 1'b1;
    end
    check_eq("sof_after_rst", n, 2 + (VT - VA) * HT + 1);

    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 2) != 0, $urandom_range(0, 9) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
